// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - size encoding, FSM states and shape check shared by the data-bus bridge
package dbus_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // True when the size code is illegal or the byte offset is not naturally aligned for it
    function automatic logic is_bad_shape(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return (off != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dbus_lane.sv
// rtl/dbus_lane.sv - load lane extract/extend and store lane merge
module dbus_lane
    import dbus_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [4:0]  w_shamt;
    logic [31:0] w_shifted;
    logic [31:0] w_lanes;
    logic [31:0] w_mask;

    assign w_shamt   = {i_off, 3'b000};
    assign w_shifted = i_word >> w_shamt;

    // Bring the addressed lane down to bit 0 and sign- or zero-extend it
    always_comb begin
        case (i_size)
            SZ_B:    o_load = {{24{~i_unsigned & w_shifted[7]}},  w_shifted[7:0]};
            SZ_H:    o_load = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default: o_load = w_shifted;
        endcase
    end

    // Replicate store data across all lanes; the mask picks the lanes actually written
    always_comb begin
        case (i_size)
            SZ_B: begin
                w_lanes = {4{i_wdata[7:0]}};
                w_mask  = 32'h0000_00FF << w_shamt;
            end
            SZ_H: begin
                w_lanes = {2{i_wdata[15:0]}};
                w_mask  = 32'h0000_FFFF << w_shamt;
            end
            default: begin
                w_lanes = i_wdata;
                w_mask  = 32'hFFFF_FFFF;
            end
        endcase
    end

    assign o_merged = (i_word & ~w_mask) | (w_lanes & w_mask);

endmodule

// File: rtl/dbus_bridge.sv
// rtl/dbus_bridge.sv - CPU load/store to word-only device bus bridge with read-modify-write
module dbus_bridge
    import dbus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_unsigned,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic        CS,
    output logic        dbus_we,
    output logic [4:0]  dbus_addr5,
    output logic [31:0] dbus_in,
    input  logic [31:0] dbus_out
);

    state_t      r_state;
    logic [4:0]  r_addr;
    logic [1:0]  r_size;
    logic        r_we;
    logic        r_uns;
    logic [31:0] r_wdata;
    logic        r_cs;
    logic        r_dwe;
    logic [31:0] r_din;
    logic        r_ready;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_fault;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    // Window and shape are judged on the live request only in IDLE, where it is accepted
    assign w_fault = (cpu_addr[31:5] != BASE_ADDR[31:5]) | is_bad_shape(cpu_size, cpu_addr[1:0]);

    // The device word being read is fed straight in; everything else comes from latched fields
    dbus_lane u_lane (
        .i_word     (dbus_out),
        .i_off      (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_merged   (w_merged)
    );

    // Transaction sequencer: accept, device read and/or write, one-cycle response
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_size  <= '0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_wdata <= '0;
            r_cs    <= 1'b0;
            r_dwe   <= 1'b0;
            r_din   <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        r_addr  <= cpu_addr[4:0];
                        r_size  <= cpu_size;
                        r_we    <= cpu_we;
                        r_uns   <= cpu_unsigned;
                        r_wdata <= cpu_wdata;
                        if (w_fault) begin
                            r_state <= ST_RESP;
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else if (cpu_we && (cpu_size == SZ_W)) begin
                            r_state <= ST_WR;
                            r_cs    <= 1'b1;
                            r_dwe   <= 1'b1;
                            r_din   <= cpu_wdata;
                        end else begin
                            r_state <= ST_RD;
                            r_cs    <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (r_we) begin
                        // Sub-word store: write back the fetched word with the new lanes merged in
                        r_state <= ST_WR;
                        r_dwe   <= 1'b1;
                        r_din   <= w_merged;
                    end else begin
                        r_state <= ST_RESP;
                        r_cs    <= 1'b0;
                        r_ready <= 1'b1;
                        r_err   <= 1'b0;
                        r_rdata <= w_load;
                    end
                end
                ST_WR: begin
                    r_state <= ST_RESP;
                    r_cs    <= 1'b0;
                    r_dwe   <= 1'b0;
                    r_din   <= '0;
                    r_ready <= 1'b1;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_err   <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_rdata  = r_rdata;
    assign cpu_ready  = r_ready;
    assign cpu_err    = r_err;
    assign CS         = r_cs;
    assign dbus_we    = r_dwe;
    assign dbus_addr5 = {r_addr[4:2], 2'b00};
    assign dbus_in    = r_din;

endmodule

// File: tb/tb_dbus_bridge.sv
// tb/tb_dbus_bridge.sv - self-checking bench for dbus_bridge against a byte-level memory model
module tb_dbus_bridge;
    import dbus_pkg::*;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [1:0]  cpu_size = '0;
    logic        cpu_unsigned = 1'b0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic        CS;
    logic        dbus_we;
    logic [4:0]  dbus_addr5;
    logic [31:0] dbus_in;
    logic [31:0] dbus_out;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    dbus_bridge #(.BASE_ADDR(BASE)) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_size     (cpu_size),
        .cpu_unsigned (cpu_unsigned),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_ready    (cpu_ready),
        .cpu_err      (cpu_err),
        .CS           (CS),
        .dbus_we      (dbus_we),
        .dbus_addr5   (dbus_addr5),
        .dbus_in      (dbus_in),
        .dbus_out     (dbus_out)
    );

    // Word-only single-cycle device
    logic [31:0] dev_mem [8] = '{32'h0, 32'h1122_3344, 32'hA1B2_C3D4, 32'h0,
                                 32'h8899_AABB, 32'h0, 32'h0, 32'h0};
    assign dbus_out = dev_mem[dbus_addr5[4:2]];
    always @(posedge clk_in) if (CS && dbus_we) dev_mem[dbus_addr5[4:2]] <= dbus_in;

    // Reference model state
    logic [31:0] ref_mem [8] = '{32'h0, 32'h1122_3344, 32'hA1B2_C3D4, 32'h0,
                                 32'h8899_AABB, 32'h0, 32'h0, 32'h0};
    logic [31:0] m_rdata = '0;

    typedef struct {
        logic        cs;
        logic        we;
        logic [4:0]  a5;
        logic [31:0] din;
        logic        rdy;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic cs, input logic we, input logic [4:0] a5,
                                input logic [31:0] din, input logic rdy, input logic err,
                                input logic [31:0] rdata);
        exp_t e;
        e.cs = cs; e.we = we; e.a5 = a5; e.din = din; e.rdy = rdy; e.err = err; e.rdata = rdata;
        return e;
    endfunction

    // Expected per-cycle bus/CPU view of one access, from byte-addressed memory semantics
    task automatic model_push(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                              input logic uns, input logic [31:0] wd, input bit lead_idle);
        int idx, off, nb;
        logic [31:0] prev, v, nw;
        logic [4:0] a5;
        bit fault;
        prev = m_rdata;
        idx  = int'(addr[4:2]);
        off  = int'(addr[1:0]);
        a5   = {addr[4:2], 2'b00};
        fault = (addr[31:5] != BASE[31:5]) || (sz == 2'd3) || ((addr % (32'd1 << sz)) != 0);
        if (lead_idle) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, prev));
        if (fault) begin
            exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0));
            m_rdata = '0;
            return;
        end
        nb = 1 << sz;
        if (!we) begin
            v = '0;
            for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[idx][8*(off+k) +: 8];
            if (!uns && nb < 4 && v[8*nb-1])
                for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
            exp_q.push_back(mk(1, 0, a5, 0, 0, 0, prev));
            exp_q.push_back(mk(0, 0, 0, 0, 1, 0, v));
            m_rdata = v;
        end else begin
            nw = ref_mem[idx];
            for (int k = 0; k < nb; k++) nw[8*(off+k) +: 8] = wd[8*k +: 8];
            if (nb < 4) exp_q.push_back(mk(1, 0, a5, 0, 0, 0, prev));
            exp_q.push_back(mk(1, 1, a5, nw, 0, 0, prev));
            exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0));
            ref_mem[idx] = nw;
            m_rdata = '0;
        end
    endtask

    // Per-cycle compare of DUT outputs against the model trace (idle when nothing is queued)
    always @(negedge clk_in) begin : compare
        exp_t e;
        if (rst) begin
            check("rst_cs", CS, 0);
            check("rst_dbus_we", dbus_we, 0);
            check("rst_addr5", dbus_addr5, 0);
            check("rst_dbus_in", dbus_in, 0);
            check("rst_ready", cpu_ready, 0);
            check("rst_err", cpu_err, 0);
            check("rst_rdata", cpu_rdata, 0);
        end else begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = mk(0, 0, 0, 0, 0, 0, m_rdata);
            check("cs", CS, e.cs);
            check("dbus_we", dbus_we, e.we);
            if (e.cs) check("addr5", dbus_addr5, e.a5);
            check("dbus_in", dbus_in, e.din);
            check("ready", cpu_ready, e.rdy);
            if (e.rdy) check("err", cpu_err, e.err);
            check("rdata", cpu_rdata, e.rdata);
        end
    end

    task automatic start(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                         input logic uns, input logic [31:0] wd, input bit lead_idle);
        cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_addr = addr;
        cpu_unsigned = uns; cpu_wdata = wd;
        model_push(we, sz, addr, uns, wd, lead_idle);
    endtask

    task automatic wait_ready(input bit scramble, output int lat);
        lat = 0;
        do begin
            @(negedge clk_in); #1;
            lat++;
            if (scramble && lat == 1) begin
                cpu_addr = ~cpu_addr; cpu_wdata = ~cpu_wdata; cpu_size = 2'd3;
                cpu_unsigned = ~cpu_unsigned; cpu_we = ~cpu_we;
            end
        end while (!cpu_ready && lat < 20);
        if (!cpu_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic access(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                          input logic uns, input logic [31:0] wd, input bit scramble, output int lat);
        @(negedge clk_in); #1;
        start(we, sz, addr, uns, wd, 1'b0);
        wait_ready(scramble, lat);
        cpu_req = 1'b0;
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk_in);
        #1 rst = 1'b0;

        access(0, SZ_B, BASE + 32'h09, 0, 0, 0, lat);
        check("lb_lat", lat, 2);
        check("lb_data", cpu_rdata, 32'hFFFF_FFC3);
        access(0, SZ_B, BASE + 32'h09, 1, 0, 0, lat);
        check("lbu_lat", lat, 2);
        check("lbu_data", cpu_rdata, 32'h0000_00C3);

        // Reset pulsed in the RD cycle of a load
        @(negedge clk_in); #1;
        start(0, SZ_W, BASE + 32'h08, 0, 0, 0);
        @(negedge clk_in); #1;
        check("pre_rst_cs", CS, 1);
        rst = 1'b1;
        #1;
        check("async_cs", CS, 0);
        check("async_ready", cpu_ready, 0);
        exp_q.delete();
        m_rdata = '0;
        cpu_req = 1'b0;
        @(negedge clk_in); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk_in);
        access(0, SZ_H, BASE + 32'h0A, 0, 0, 0, lat);
        check("lh_lat", lat, 2);
        check("lh_data", cpu_rdata, 32'hFFFF_A1B2);

        access(1, SZ_B, BASE + 32'h0A, 0, 32'h0000_005A, 0, lat);
        check("sb_lat", lat, 3);
        check("sb_word", dev_mem[2], 32'hA15A_C3D4);
        check("sb_rdata", cpu_rdata, 0);

        access(1, SZ_W, BASE + 32'h10, 0, 32'h1234_5678, 0, lat);
        check("sw_lat", lat, 2);
        check("sw_word", dev_mem[4], 32'h1234_5678);

        access(0, SZ_W, BASE + 32'h02, 0, 0, 0, lat);
        check("flt_mis_lat", lat, 1);
        check("flt_mis_err", cpu_err, 1);
        access(0, SZ_W, BASE + 32'h40, 0, 0, 0, lat);
        check("flt_win_lat", lat, 1);
        check("flt_win_err", cpu_err, 1);
        access(0, 2'd3, BASE, 0, 0, 0, lat);
        check("flt_sz3_err", cpu_err, 1);
        access(1, SZ_H, BASE + 32'h01, 0, 32'hFFFF, 0, lat);
        check("flt_sh_err", cpu_err, 1);
        check("flt_rdata", cpu_rdata, 0);

        // Inputs scrambled after acceptance must not disturb the store
        access(1, SZ_H, BASE + 32'h06, 0, 32'h0000_BEEF, 1, lat);
        check("sh_lat", lat, 3);
        access(0, SZ_W, BASE + 32'h04, 0, 0, 0, lat);
        check("lw_after_sh", cpu_rdata, 32'hBEEF_3344);

        // Back-to-back: request held high, replaced in the ready cycle
        @(negedge clk_in); #1;
        start(0, SZ_W, BASE + 32'h10, 0, 0, 0);
        wait_ready(0, lat);
        check("b2b_first_lat", lat, 2);
        check("b2b_first_data", cpu_rdata, 32'h1234_5678);
        start(0, SZ_H, BASE + 32'h0A, 1, 0, 1);
        wait_ready(0, lat);
        cpu_req = 1'b0;
        check("b2b_ready_spacing", lat, 3);
        check("b2b_second_data", cpu_rdata, 32'h0000_A15A);

        repeat (3) @(negedge clk_in);
        check("trace_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/dbus_bridge.md
DBUS_BRIDGE -- requirements
Module: dbus_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0200_0000, meaning the device window base, 32-byte aligned, 32 bytes long.
REQ-002 SHALL have ports clk_in (in, 1) as the only clock and rst (in, 1) as the reset; reset is asynchronous and active-high.
REQ-003 SHALL have cpu_req (in, 1): access request, level, held until cpu_ready.
REQ-004 SHALL have cpu_we (in, 1): 1 = store, 0 = load.
REQ-005 SHALL have cpu_addr (in, 32): byte address.
REQ-006 SHALL have cpu_size (in, 2): 0 byte, 1 half, 2 word; 3 is illegal.
REQ-007 SHALL have cpu_unsigned (in, 1): zero-extend loads when 1.
REQ-008 SHALL have cpu_wdata (in, 32): store data in the low bits.
REQ-009 SHALL have cpu_rdata (out, 32): extended load data, valid with cpu_ready.
REQ-010 SHALL have cpu_ready (out, 1): one-cycle completion pulse.
REQ-011 SHALL have cpu_err (out, 1): access fault, valid with cpu_ready.
REQ-012 SHALL have device-side outputs CS (1), dbus_we (1), dbus_addr5 (5) and dbus_in (32), plus input dbus_out (32): a word-only, single-cycle responder port.

Function
REQ-013 SHALL implement states IDLE, RD, WR and RESP.
REQ-014 SHALL sample cpu_req only in IDLE, and on acceptance SHALL latch addr, size, we, unsigned and wdata; later input changes are ignored.
REQ-015 SHALL fault an access that is misaligned (half at odd address, word not a multiple of 4), out of window (addr[31:5] != BASE_ADDR[31:5]) or has size 3: IDLE -> RESP with cpu_err=1 and no CS.
REQ-016 SHALL sequence a load as IDLE -> RD -> RESP, capturing dbus_out at the end of RD.
REQ-017 SHALL sequence a word store as IDLE -> WR -> RESP.
REQ-018 SHALL sequence a byte or half store as IDLE -> RD -> WR -> RESP (read-modify-write), merging the new lanes into the captured word and preserving the other lanes.
REQ-019 SHALL assert CS only in RD and WR, with dbus_we=1 only in WR, dbus_addr5={addr[4:2],2'b00}, and dbus_in=merged word in WR and 0 otherwise.
REQ-020 SHALL drive device-side outputs only from the state and latched registers, with no combinational path from cpu_* inputs.
REQ-021 SHALL, in RESP, assert cpu_ready for exactly one cycle, then return to IDLE.
REQ-022 SHALL hold cpu_rdata stable until the next RESP and SHALL present 0 for stores and faults.
REQ-023 SHALL produce a load result by shifting the lane selected by addr[1:0] down and sign-extending it, or zero-extending it when cpu_unsigned=1.
REQ-024 SHALL give latency from acceptance to cpu_ready of 2 cycles for loads and word stores, 3 for sub-word stores, and 1 for faults.
REQ-025 SHALL allow a cpu_req that is still high in the IDLE cycle after RESP to start a new transaction; the CPU drops or replaces the request in that cycle.

Reset
REQ-026 SHALL, while rst=1, immediately force the state to IDLE and drive CS, dbus_we, dbus_addr5, dbus_in, cpu_ready, cpu_err and cpu_rdata to 0, and clear all latched registers.
REQ-027 SHALL, on reset mid-transaction, abort without completion: no further CS and no cpu_ready for that request.

Structure
REQ-028 SHALL take the size encoding (SZ_B, SZ_H, SZ_W) and the state enum from shared package dbus_pkg.
REQ-029 SHALL place lane extract/extend and store-merge logic in the combinational sub-module dbus_lane.

Verification
REQ-030 SHALL cover a load: with the device word at 0x08 = 0xA1B2C3D4, lb at BASE+0x09 -> cpu_rdata=0xFFFFFFC3, and lbu -> 0x000000C3, each with cpu_ready 2 cycles after acceptance.
REQ-031 SHALL cover a byte store: sb 0x5A at BASE+0x0A -> RD cycle at addr5=0x08, then WR of 0xA15AC3D4, then cpu_ready, with cpu_ready 3 cycles after acceptance.
REQ-032 SHALL cover a word store: sw 0x12345678 at BASE+0x10 -> a single WR cycle (CS=1, dbus_we=1, addr5=0x10), no RD cycle, cpu_ready 2 cycles after acceptance.
REQ-033 SHALL cover faults: lw at BASE+0x02 and lw at BASE+0x40 -> cpu_err=1 with cpu_ready 1 cycle after acceptance, and CS never asserted.
REQ-034 SHALL cover reset mid-operation: rst pulsed during RD of a load -> CS falls without waiting for a clock, no cpu_ready, and a following lh at BASE+0x0A -> 0xFFFFA1B2.
REQ-035 SHALL cover back-to-back requests: cpu_req held high across two loads -> two cpu_ready pulses separated by 2 cycles, with cpu_rdata correct for each.
